lsu_mem_stage: RTL and testbench
================================

// Module: lsu_mem_stage
// PURPOSE
//  Load/store unit for the memory stage, directly downstream of the control decoder.
//  Consumes load/memwrite/storeops/funct plus ALU address and rs2 data.
//  Runs one data-memory transaction over a req/ack bus, with byte-lane steering and load extension.
//  Holds the pipeline via stall until the access completes, is rejected, or times out.
// PARAMETERS
//  WAIT_MAX  255  max BUSY cycles without dmem_ack before abort (1..255, 8-bit counter)
// PORTS
//  clk            in   1   clock, rising edge
//  rst_n          in   1   asynchronous reset, active low
//  load           in   1   memory-stage instr is a load
//  memwrite       in   1   memory-stage instr is a store
//  storeops       in   2   0=none 1=byte 2=half 3=word
//  funct          in   3   load funct3: 000 LB 001 LH 010 LW 100 LBU 101 LHU
//  addr           in   32  effective byte address (ALU result)
//  wdata          in   32  store data (rs2)
//  stall          out  1   hold upstream pipeline this cycle
//  rdata_out      out  32  extended load result for writeback
//  rdata_valid    out  1   1-cycle pulse: rdata_out updated
//  misalign_err   out  1   1-cycle pulse: misaligned access rejected
//  bus_err        out  1   1-cycle pulse: access aborted on timeout
//  dmem_req       out  1   bus request, held until ack
//  dmem_we        out  1   1=write 0=read
//  dmem_addr      out  32  word address ({addr[31:2],2'b00})
//  dmem_be        out  4   byte enables
//  dmem_wdata     out  32  lane-replicated store data
//  dmem_ack       in   1   bus completion, sampled while dmem_req=1
//  dmem_rdata     in   32  read word, valid with dmem_ack on reads
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=IDLE. All registered outputs and wait counter = 0.
//    dmem_req drops immediately; an in-flight access is abandoned with no error pulse.
//  - FSM IDLE -> BUSY -> DONE -> IDLE. Operation op = load | (memwrite & storeops!=0).
//    load has priority when load and memwrite are both 1.
//    memwrite with storeops=0 is a no-op.
//  - IDLE: op & aligned -> latch dmem_* regs, go BUSY; stall=1 combinationally this cycle.
//    op & misaligned -> no bus access, stall=0, misalign_err=1 next cycle.
//    Misaligned = half with addr[0]=1, or word with addr[1:0]!=0.
//  - BUSY: dmem_req=1; dmem_addr/we/be/wdata stable; stall=1; counter increments each cycle.
//    dmem_ack=1 -> DONE. On load, rdata_out <= ext(dmem_rdata) and rdata_valid=1 in DONE.
//    Counter reaches WAIT_MAX without ack -> DONE, dmem_req drops, bus_err=1, rdata_out unchanged.
//  - DONE: stall=0, inputs ignored (the completed instr is still presented); -> IDLE next.
//    Pulses are 1 cycle. Back-to-back accesses are spaced by the DONE cycle.
//  - Latency: ack on the Nth BUSY cycle -> stall high N+1 cycles; zero-wait ack -> 2.
//  - Stores: byte be=1<<addr[1:0], wdata={4{wdata[7:0]}}; half be=addr[1]?1100:0011,
//    wdata={2{wdata[15:0]}}; word be=1111.
//  - Loads: be=1111, dmem_we=0. Lane = addr[1:0] (byte) / addr[1] (half).
//    LB/LH sign-extend; LBU/LHU zero-extend; funct 011/110/111 treated as LW.
//  - dmem_ack while dmem_req=0 is ignored.
// TESTING
//  1 SB addr=0x1003 wdata=0xA5, ack on 3rd BUSY cycle -> dmem_addr=0x1000, be=1000,
//    dmem_wdata=0xA5A5A5A5, stall high 4 cycles, no rdata_valid.
//  2 LB addr=0x2001, dmem_rdata=0x1234F0AB -> rdata_out=0xFFFFFFF0;
//    same with LBU -> 0x000000F0; LH addr=0x2002 -> 0x00001234; rdata_valid 1 cycle each.
//  3 LH addr=0x2003 -> dmem_req never rises, stall=0, misalign_err=1 for 1 cycle next cycle.
//  4 WAIT_MAX=4, LW never acked -> dmem_req high exactly 4 cycles, then bus_err 1 cycle,
//    rdata_valid=0, rdata_out unchanged.
//  5 rst_n=0 mid-BUSY -> dmem_req=0 and stall=0 without a clock edge;
//    after release, a new SW completes normally.
//  6 Zero-wait ack, SW then LW back-to-back -> each stall 2 cycles, DONE cycle between,
//    no duplicate request for the first instr.

Source files
------------

// File: rtl/lsu_mem_stage.sv
// Memory-stage load/store unit: one req/ack data-memory access per instruction,
// with byte-lane steering for stores, load extension, misalignment rejection and timeout.
module lsu_mem_stage #(
  parameter int unsigned WAIT_MAX = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        memwrite,
  input  logic [1:0]  storeops,
  input  logic [2:0]  funct,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic [31:0] rdata_out,
  output logic        rdata_valid,
  output logic        misalign_err,
  output logic        bus_err,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata
);

  localparam int unsigned DW = 32;
  localparam int unsigned BW = 4;
  localparam int unsigned CW = 8;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic          dmem_req_q, dmem_req_d;
  logic          dmem_we_q, dmem_we_d;
  logic [DW-1:0] dmem_addr_q, dmem_addr_d;
  logic [BW-1:0] dmem_be_q, dmem_be_d;
  logic [DW-1:0] dmem_wdata_q, dmem_wdata_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          rvalid_q, rvalid_d;
  logic          mis_q, mis_d;
  logic          berr_q, berr_d;
  logic          is_load_q, is_load_d;
  logic [2:0]    funct_q, funct_d;
  logic [1:0]    lane_q, lane_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          op_c;
  logic          misalign_c;
  logic          go_c;
  logic          timeout_c;
  logic [1:0]    size_c;
  logic [BW-1:0] be_c;
  logic [DW-1:0] wdata_c;

  // Sign/zero extension of the selected lane; funct 011/110/111 fall through to word.
  function automatic logic [DW-1:0] load_ext(input logic [2:0] f, input logic [1:0] lane,
                                             input logic [DW-1:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{lane, 3'b000} +: 8];
    h = lane[1] ? w[31:16] : w[15:0];
    case (f[1:0])
      2'b00:   return f[2] ? {24'd0, b} : {{24{b[7]}}, b};
      2'b01:   return f[2] ? {16'd0, h} : {{16{h[15]}}, h};
      default: return w;
    endcase
  endfunction

  // Request decode: access size, alignment and lane steering (load wins over store).
  always_comb begin
    op_c = load | (memwrite & (storeops != 2'd0));
    size_c = SZ_W;
    if (load) begin
      case (funct[1:0])
        2'b00:   size_c = SZ_B;
        2'b01:   size_c = SZ_H;
        default: size_c = SZ_W;
      endcase
    end else begin
      case (storeops)
        2'd1:    size_c = SZ_B;
        2'd2:    size_c = SZ_H;
        default: size_c = SZ_W;
      endcase
    end
    misalign_c = ((size_c == SZ_H) & addr[0]) | ((size_c == SZ_W) & (addr[1:0] != 2'd0));
    go_c = op_c & ~misalign_c;

    be_c    = 4'b1111;
    wdata_c = wdata;
    if (!load) begin
      case (size_c)
        SZ_B: begin
          be_c    = BW'(4'b0001 << addr[1:0]);
          wdata_c = {4{wdata[7:0]}};
        end
        SZ_H: begin
          be_c    = addr[1] ? 4'b1100 : 4'b0011;
          wdata_c = {2{wdata[15:0]}};
        end
        default: begin
          be_c    = 4'b1111;
          wdata_c = wdata;
        end
      endcase
    end
  end

  assign timeout_c = (cnt_q == CW'(WAIT_MAX - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (go_c) state_d = S_BUSY;
      S_BUSY:  if (dmem_ack || timeout_c) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Stall covers the issuing IDLE cycle plus every BUSY cycle; forced low while in reset.
  always_comb begin
    stall = 1'b0;
    if (rst_n) begin
      stall = ((state_q == S_IDLE) & go_c) | (state_q == S_BUSY);
    end
  end

  always_comb begin
    dmem_req_d   = dmem_req_q;
    dmem_we_d    = dmem_we_q;
    dmem_addr_d  = dmem_addr_q;
    dmem_be_d    = dmem_be_q;
    dmem_wdata_d = dmem_wdata_q;
    rdata_d      = rdata_q;
    rvalid_d     = 1'b0;
    mis_d        = 1'b0;
    berr_d       = 1'b0;
    is_load_d    = is_load_q;
    funct_d      = funct_q;
    lane_d       = lane_q;
    cnt_d        = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (go_c) begin
          dmem_req_d   = 1'b1;
          dmem_we_d    = ~load;
          dmem_addr_d  = {addr[31:2], 2'b00};
          dmem_be_d    = be_c;
          dmem_wdata_d = wdata_c;
          is_load_d    = load;
          funct_d      = funct;
          lane_d       = addr[1:0];
          cnt_d        = '0;
        end else if (op_c) begin
          mis_d = 1'b1;
        end
      end
      S_BUSY: begin
        if (dmem_ack) begin
          dmem_req_d = 1'b0;
          if (is_load_q) begin
            rdata_d  = load_ext(funct_q, lane_q, dmem_rdata);
            rvalid_d = 1'b1;
          end
        end else if (timeout_c) begin
          dmem_req_d = 1'b0;
          berr_d     = 1'b1;
        end else begin
          cnt_d = CW'(cnt_q + 1'b1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dmem_req_q   <= 1'b0;
      dmem_we_q    <= 1'b0;
      dmem_addr_q  <= '0;
      dmem_be_q    <= '0;
      dmem_wdata_q <= '0;
      rdata_q      <= '0;
      rvalid_q     <= 1'b0;
      mis_q        <= 1'b0;
      berr_q       <= 1'b0;
      is_load_q    <= 1'b0;
      funct_q      <= '0;
      lane_q       <= '0;
      cnt_q        <= '0;
    end else begin
      dmem_req_q   <= dmem_req_d;
      dmem_we_q    <= dmem_we_d;
      dmem_addr_q  <= dmem_addr_d;
      dmem_be_q    <= dmem_be_d;
      dmem_wdata_q <= dmem_wdata_d;
      rdata_q      <= rdata_d;
      rvalid_q     <= rvalid_d;
      mis_q        <= mis_d;
      berr_q       <= berr_d;
      is_load_q    <= is_load_d;
      funct_q      <= funct_d;
      lane_q       <= lane_d;
      cnt_q        <= cnt_d;
    end
  end

  assign dmem_req     = dmem_req_q;
  assign dmem_we      = dmem_we_q;
  assign dmem_addr    = dmem_addr_q;
  assign dmem_be      = dmem_be_q;
  assign dmem_wdata   = dmem_wdata_q;
  assign rdata_out    = rdata_q;
  assign rdata_valid  = rvalid_q;
  assign misalign_err = mis_q;
  assign bus_err      = berr_q;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Directed bench for lsu_mem_stage: bus-side checks inline, result/error pulses
// matched against a queue of expected events.
module tb_lsu_mem_stage;

  logic        clk;
  logic        rst_n;
  logic        load;
  logic        memwrite;
  logic [1:0]  storeops;
  logic [2:0]  funct;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        stall;
  logic [31:0] rdata_out;
  logic        rdata_valid;
  logic        misalign_err;
  logic        bus_err;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;

  lsu_mem_stage #(.WAIT_MAX(4)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .memwrite(memwrite), .storeops(storeops),
    .funct(funct), .addr(addr), .wdata(wdata), .stall(stall), .rdata_out(rdata_out),
    .rdata_valid(rdata_valid), .misalign_err(misalign_err), .bus_err(bus_err),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata)
  );

  // Event kinds as {rdata_valid, misalign_err, bus_err}
  localparam logic [2:0] EV_RD  = 3'b100;
  localparam logic [2:0] EV_MIS = 3'b010;
  localparam logic [2:0] EV_BUS = 3'b001;

  typedef struct {
    logic [2:0]  kind;
    logic [31:0] data;
  } sb_item_t;

  sb_item_t sb_q[$];
  int tests = 0;
  int fails = 0;
  logic [31:0] exp_last;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [2:0] kind, input logic [31:0] data);
    sb_item_t it;
    it.kind = kind;
    it.data = data;
    sb_q.push_back(it);
  endtask

  // Every result/error pulse must match the oldest expected event.
  always @(negedge clk) begin : mon
    logic [2:0] ev;
    sb_item_t   it;
    ev = {rdata_valid, misalign_err, bus_err};
    if (rst_n && ev != 3'b000) begin
      tests++;
      assert (sb_q.size() > 0) else begin
        fails++;
        $error("FAIL unexpected_event observed=%b expected=none", ev);
      end
      if (sb_q.size() > 0) begin
        it = sb_q.pop_front();
        tests++;
        assert (ev === it.kind && rdata_out === it.data) else begin
          fails++;
          $error("FAIL event observed=%b/0x%08h expected=%b/0x%08h", ev, rdata_out, it.kind, it.data);
        end
      end
    end
  end

  task automatic drive_idle();
    load = 1'b0; memwrite = 1'b0; storeops = 2'd0; funct = 3'd0;
    addr = '0; wdata = '0; dmem_ack = 1'b0; dmem_rdata = '0;
  endtask

  // Presents one instruction until stall drops; ack_at = BUSY cycle carrying ack (0 = never).
  task automatic run_access(input logic ld, input logic mw, input logic [1:0] so,
                            input logic [2:0] fn, input logic [31:0] a, input logic [31:0] wd,
                            input int ack_at, input logic [31:0] rd,
                            output int n_stall, output int n_req, output logic [31:0] o_addr,
                            output logic [3:0] o_be, output logic [31:0] o_wdata,
                            output logic o_we);
    int  busy_idx;
    bit  done;
    @(negedge clk);
    load = ld; memwrite = mw; storeops = so; funct = fn; addr = a; wdata = wd;
    dmem_ack = 1'b0; dmem_rdata = rd;
    #1;
    n_stall = 0; n_req = 0; busy_idx = 0; done = 1'b0;
    o_addr = '0; o_be = '0; o_wdata = '0; o_we = 1'b0;
    if (stall) n_stall++;
    else done = 1'b1;
    for (int c = 0; c < 32 && !done; c++) begin
      @(negedge clk);
      busy_idx++;
      dmem_ack = (busy_idx == ack_at);
      #1;
      if (busy_idx == 1) begin
        o_addr = dmem_addr; o_be = dmem_be; o_wdata = dmem_wdata; o_we = dmem_we;
      end
      if (dmem_req) n_req++;
      if (stall) n_stall++;
      else done = 1'b1;
    end
    dmem_ack = 1'b0;
    chk("access_completes", 32'(done), 32'd1);
  endtask

  initial begin
    int n_stall, n_req;
    logic [31:0] o_addr, o_wdata;
    logic [3:0]  o_be;
    logic        o_we;

    rst_n = 1'b0;
    drive_idle();
    exp_last = 32'd0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_req", 32'(dmem_req), 32'd0);
    chk("rst_rdata", rdata_out, 32'd0);
    chk("rst_pulses", 32'({rdata_valid, misalign_err, bus_err}), 32'd0);
    chk("rst_addr_be", {dmem_addr[27:0], dmem_be}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // SB, ack on 3rd BUSY cycle
    run_access(1'b0, 1'b1, 2'd1, 3'd0, 32'h0000_1003, 32'h0000_00A5, 3, 32'h0,
               n_stall, n_req, o_addr, o_be, o_wdata, o_we);
    chk("sb_stall", 32'(n_stall), 32'd4);
    chk("sb_addr", o_addr, 32'h0000_1000);
    chk("sb_be", 32'(o_be), 32'b1000);
    chk("sb_wdata", o_wdata, 32'hA5A5_A5A5);
    chk("sb_we", 32'(o_we), 32'd1);

    // SH upper half
    run_access(1'b0, 1'b1, 2'd2, 3'd0, 32'h0000_5002, 32'h1234_ABCD, 1, 32'h0,
               n_stall, n_req, o_addr, o_be, o_wdata, o_we);
    chk("sh_be", 32'(o_be), 32'b1100);
    chk("sh_wdata", o_wdata, 32'hABCD_ABCD);

    // Loads with extension
    push(EV_RD, 32'hFFFF_FFF0);
    run_access(1'b1, 1'b0, 2'd0, 3'b000, 32'h0000_2001, 32'h0, 1, 32'h1234_F0AB,
               n_stall, n_req, o_addr, o_be, o_wdata, o_we);
    chk("lb_stall", 32'(n_stall), 32'd2);
    chk("lb_be_we", {o_be, 27'd0, o_we}, {4'b1111, 28'd0});
    chk("lb_addr", o_addr, 32'h0000_2000);
    push(EV_RD, 32'h0000_00F0);
    run_access(1'b1, 1'b0, 2'd0, 3'b100, 32'h0000_2001, 32'h0, 1, 32'h1234_F0AB,
               n_stall, n_req, o_addr, o_be, o_wdata, o_we);
    push(EV_RD, 32'h0000_1234);
    run_access(1'b1, 1'b0, 2'd0, 3'b001, 32'h0000_2002, 32'h0, 1, 32'h1234_F0AB,
               n_stall, n_req, o_addr, o_be, o_wdata, o_we);
    exp_last = 32'h0000_1234;
    @(negedge clk);
    drive_idle();
    @(negedge clk);
    chk("loads_drained", 32'(sb_q.size()), 32'd0);

    // Misaligned LH: no bus access, single error pulse
    push(EV_MIS, exp_last);
    @(negedge clk);
    load = 1'b1; funct = 3'b001; addr = 32'h0000_2003;
    #1;
    chk("mis_stall", 32'(stall), 32'd0);
    @(negedge clk);
    drive_idle();
    #1;
    chk("mis_req", 32'(dmem_req), 32'd0);
    repeat (2) @(negedge clk);
    chk("mis_drained", 32'(sb_q.size()), 32'd0);

    // LW never acked: timeout after 4 BUSY cycles
    push(EV_BUS, exp_last);
    run_access(1'b1, 1'b0, 2'd0, 3'b010, 32'h0000_3000, 32'h0, 0, 32'hFFFF_FFFF,
               n_stall, n_req, o_addr, o_be, o_wdata, o_we);
    chk("to_req_cycles", 32'(n_req), 32'd4);
    chk("to_stall", 32'(n_stall), 32'd5);
    chk("to_rdata_kept", rdata_out, 32'h0000_1234);

    // Zero-wait SW then LW back-to-back
    run_access(1'b0, 1'b1, 2'd3, 3'd0, 32'h0000_4000, 32'hDEAD_BEEF, 1, 32'h0,
               n_stall, n_req, o_addr, o_be, o_wdata, o_we);
    chk("b2b_sw_stall", 32'(n_stall), 32'd2);
    chk("b2b_sw_req", 32'(n_req), 32'd1);
    chk("b2b_sw_wdata", o_wdata, 32'hDEAD_BEEF);
    chk("b2b_done_req", 32'(dmem_req), 32'd0);
    push(EV_RD, 32'hCAFE_F00D);
    run_access(1'b1, 1'b0, 2'd0, 3'b010, 32'h0000_4004, 32'h0, 1, 32'hCAFE_F00D,
               n_stall, n_req, o_addr, o_be, o_wdata, o_we);
    chk("b2b_lw_stall", 32'(n_stall), 32'd2);
    chk("b2b_lw_addr", o_addr, 32'h0000_4004);

    // Reset mid-BUSY, then a fresh SW
    @(negedge clk);
    load = 1'b0; memwrite = 1'b1; storeops = 2'd3; addr = 32'h0000_6000; wdata = 32'h11;
    @(negedge clk);
    #1;
    chk("rb_req_busy", 32'(dmem_req), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rb_req_async", 32'(dmem_req), 32'd0);
    chk("rb_stall_async", 32'(stall), 32'd0);
    exp_last = 32'd0;
    @(negedge clk);
    drive_idle();
    @(negedge clk);
    rst_n = 1'b1;
    run_access(1'b0, 1'b1, 2'd3, 3'd0, 32'h0000_6004, 32'h0000_0055, 1, 32'h0,
               n_stall, n_req, o_addr, o_be, o_wdata, o_we);
    chk("rb_sw_stall", 32'(n_stall), 32'd2);
    chk("rb_sw_addr", o_addr, 32'h0000_6004);
    chk("rb_sw_be", 32'(o_be), 32'b1111);

    @(negedge clk);
    drive_idle();
    repeat (3) @(negedge clk);
    chk("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
